// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: valid/data pipeline with stall bubbles, youngest-stage flush and saturating stats
module pipe_stage_chain #(
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 4,
  parameter int FLUSH_STAGES = 3,
  localparam int IW          = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              stall_en,
  input  logic [IW-1:0]     stall_idx,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IW-1:0]     occupancy,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
);
  logic [DEPTH-1:0]  r_v, w_v, w_sv;
  logic [DATA_W-1:0] r_d [DEPTH];
  logic [DATA_W-1:0] w_d [DEPTH];
  logic [DATA_W-1:0] w_sd [DEPTH];
  logic [IW-1:0]     r_occ, w_occ;
  logic [15:0]       r_bub, r_fc, w_kill;
  logic [16:0]       w_fsum;
  logic              w_stall, w_bub;
  assign w_stall   = stall_en && stall_idx != '0 && stall_idx <= IW'(DEPTH);
  assign w_bub     = w_stall && stall_idx != IW'(DEPTH) && !(flush && stall_idx < IW'(FLUSH_STAGES));
  assign in_ready  = ~flush & ~w_stall;
  assign w_fsum    = {1'b0, r_fc} + {1'b0, w_kill};
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign occupancy = r_occ;
  assign bubble_cnt = r_bub;
  assign flush_cnt = r_fc;
  // next stage contents: flush clears youngest stages, stall holds below and bubbles at the boundary
  always_comb begin
    w_sv = {r_v[DEPTH-2:0], in_valid};
    w_sd[0] = in_valid ? in_data : '0;
    for (int k = 1; k < DEPTH; k++) w_sd[k] = r_d[k-1];
    w_occ = '0;
    w_kill = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((flush && k < FLUSH_STAGES) || (w_stall && IW'(k) == stall_idx)) begin
        w_v[k] = 1'b0;
        w_d[k] = '0;
      end else if (w_stall && IW'(k) < stall_idx) begin
        w_v[k] = r_v[k];
        w_d[k] = r_d[k];
      end else begin
        w_v[k] = w_sv[k];
        w_d[k] = w_sd[k];
      end
      w_occ = w_occ + IW'(w_v[k]);
      if (flush && k < FLUSH_STAGES) w_kill = w_kill + 16'(r_v[k]);
    end
  end
  // stage registers and saturating statistics, updated on the falling clock edge
  always_ff @(negedge CLK) begin
    if (Reset) begin
      r_v   <= '0;
      r_occ <= '0;
      r_bub <= '0;
      r_fc  <= '0;
      for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
    end else begin
      r_v   <= w_v;
      r_occ <= w_occ;
      r_bub <= r_bub + 16'(w_bub && r_bub != 16'hFFFF);
      r_fc  <= w_fsum[16] ? 16'hFFFF : w_fsum[15:0];
      for (int k = 0; k < DEPTH; k++) r_d[k] <= w_d[k];
    end
  end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed scoreboard bench for pipe_stage_chain (DEPTH=4, FLUSH_STAGES=3)
module tb_pipe_stage_chain;
  localparam int DW = 64;
  localparam int IW = 3;
  logic          CLK = 1'b0;
  logic          Reset, in_valid, stall_en, flush;
  logic [DW-1:0] in_data;
  logic [IW-1:0] stall_idx;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] occupancy;
  logic [15:0]   bubble_cnt, flush_cnt;
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] last = '0;

  pipe_stage_chain #(.DATA_W(DW), .DEPTH(4), .FLUSH_STAGES(3)) dut (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_en(stall_en), .stall_idx(stall_idx), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .occupancy(occupancy), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic se,
                       input logic [IW-1:0] si, input logic fl, input logic rs);
    in_valid = v; in_data = d; stall_en = se; stall_idx = si; flush = fl; Reset = rs;
  endtask

  task automatic tick(input string tag, input logic ev, input logic frz, input int occ, input int kill);
    logic er;
    #1;
    er = !flush && !(stall_en && stall_idx != '0);
    chk({tag, ":rdy"}, 64'(in_ready), 64'(er));
    if (in_valid && er && !Reset) q.push_back(in_data);
    @(negedge CLK);
    #1;
    if (Reset) q.delete();
    chk({tag, ":ov"}, 64'(out_valid), 64'(ev));
    if (!ev) chk({tag, ":od0"}, out_data, '0);
    else if (frz) chk({tag, ":hold"}, out_data, last);
    else if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s:sb obs=%h exp=<none>", tag, out_data);
    end else begin
      last = q.pop_front();
      chk({tag, ":od"}, out_data, last);
    end
    for (int j = 0; j < kill; j++) void'(q.pop_back());
    chk({tag, ":occ"}, 64'(occupancy), 64'(occ));
  endtask

  task automatic fill(input logic [DW-1:0] base, input logic se);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, base + DW'(i) * 64'h0001_0000_0000_0011, se, '0, 1'b0, 1'b0);
      tick("fill", i == 3, 1'b0, i + 1, 0);
    end
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick("drain", i < 3, 1'b0, 3 - i, 0);
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    tick("rst0", 1'b0, 1'b0, 0, 0);
    tick("rst1", 1'b0, 1'b0, 0, 0);
    chk("rst_bub", 64'(bubble_cnt), 64'h0);
    chk("rst_fc", 64'(flush_cnt), 64'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'hA5A5_0000_1234_0000 + DW'(i) * 64'h0100_0000_0000_0101, 1'b0, '0, 1'b0, 1'b0);
      tick("strm", i >= 3, 1'b0, i < 3 ? i + 1 : 4, 0);
    end
    drain();
    fill(64'hB000_0000_0000_0100, 1'b0);
    drive(1'b1, 64'hBAD0, 1'b1, 3'd2, 1'b0, 1'b0);
    tick("stall2", 1'b1, 1'b0, 3, 0);
    chk("stall2_bub", 64'(bubble_cnt), 64'd1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    tick("bubble_out", 1'b0, 1'b0, 2, 0);
    tick("post_c", 1'b1, 1'b0, 2, 0);
    tick("post_d", 1'b1, 1'b0, 1, 0);
    tick("post_e", 1'b0, 1'b0, 0, 0);
    fill(64'hC000_0000_0000_0200, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    tick("flush", 1'b1, 1'b0, 1, 2);
    chk("flush_fc", 64'(flush_cnt), 64'd3);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    tick("flush_after", 1'b0, 1'b0, 0, 0);
    fill(64'hD000_0000_0000_0300, 1'b1);
    chk("idx0_bub", 64'(bubble_cnt), 64'd1);
    drive(1'b1, 64'hBAD2, 1'b1, 3'd4, 1'b1, 1'b0);
    tick("fl_frz", 1'b1, 1'b1, 1, 3);
    chk("fl_frz_bub", 64'(bubble_cnt), 64'd1);
    chk("fl_frz_fc", 64'(flush_cnt), 64'd6);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    tick("frz_after", 1'b0, 1'b0, 0, 0);
    drive(1'b0, '0, 1'b1, 3'd1, 1'b0, 1'b0);
    repeat (65533) @(negedge CLK);
    #1;
    chk("sat_fffe", 64'(bubble_cnt), 64'hFFFE);
    tick("sat1", 1'b0, 1'b0, 0, 0);
    chk("sat_ffff", 64'(bubble_cnt), 64'hFFFF);
    tick("sat2", 1'b0, 1'b0, 0, 0);
    chk("sat_stay", 64'(bubble_cnt), 64'hFFFF);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    fill(64'hE000_0000_0000_0400, 1'b0);
    drive(1'b1, 64'hBAD3, 1'b1, 3'd2, 1'b1, 1'b1);
    tick("rst_full", 1'b0, 1'b0, 0, 0);
    chk("rst_full_bub", 64'(bubble_cnt), 64'h0);
    chk("rst_full_fc", 64'(flush_cnt), 64'h0);
    drive(1'b1, 64'hBAD4, 1'b0, '0, 1'b0, 1'b1);
    tick("rst_rdy", 1'b0, 1'b0, 0, 0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick("rst_empty", 1'b0, 1'b0, 0, 0);
    fill(64'hF000_0000_0000_0500, 1'b0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
